neuron_mac: RTL and testbench

Single-neuron multiply-accumulate stage that directly feeds the `NeuralAccelerator` 8-bit `out` path. It consumes a stream of signed 8-bit activation/weight pairs over a valid/ready handshake and accumulates N_INPUTS products. It then adds a bias, rescales, applies ReLU and saturation, and presents one unsigned 8-bit neuron output over a second valid/ready handshake.

---
 rtl/nn_pkg.sv | 28 ++
 rtl/mac_unit.sv | 43 ++++
 rtl/neuron_mac.sv | 118 +++++++++++
 tb/tb_neuron_mac.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared neural-layer definitions: data width, neuron FSM states and the
// ReLU/saturate-to-8-bit clamp used by every layer that emits 8-bit results.
package nn_pkg;

    localparam int DATA_W = 8;
    localparam int WIDE_W = 64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ACT   = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Clamp a signed value to the unsigned 8-bit range: negatives become 0,
    // anything above 255 becomes 255.
    function automatic logic [7:0] relu_sat8(input logic signed [WIDE_W-1:0] x);
        logic [7:0] r;
        if (x < 0) begin
            r = 8'd0;
        end else if (x > 64'sd255) begin
            r = 8'd255;
        end else begin
            r = x[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed DATA_W x DATA_W multiply accumulated into an ACC_W-bit register.
// Clear has priority over enable so a clear always starts a fresh sum.
module mac_unit
    import nn_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    // Next accumulator value: clear, add the sign-extended product, or hold.
    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    // Accumulator register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: accumulate N_INPUTS signed activation*weight products,
// add bias, arithmetic-shift, ReLU/saturate to 8 bits and hand the result
// downstream over a valid/ready handshake.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int SHIFT    = 0,
    parameter int ACC_W    = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] in_weight,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    // Parameter sanity: reject configurations where the sum could wrap.
    if (N_INPUTS < 1 || N_INPUTS > 256) begin : g_n_chk
        $error("neuron_mac: N_INPUTS must be in 1..256");
    end
    if (SHIFT < 0 || SHIFT > 15) begin : g_shift_chk
        $error("neuron_mac: SHIFT must be in 0..15");
    end
    if (ACC_W < 2*DATA_W + $clog2(N_INPUTS) + 1) begin : g_accw_chk
        $error("neuron_mac: ACC_W too narrow for N_INPUTS products");
    end
    if (ACC_W > WIDE_W - 2) begin : g_accw_max_chk
        $error("neuron_mac: ACC_W too wide for the activation clamp");
    end

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [7:0]               out_q, out_d;
    logic signed [ACC_W-1:0]  acc;
    logic                     accept;
    logic signed [ACC_W:0]    sum_w;
    logic signed [ACC_W:0]    shifted;
    logic signed [WIDE_W-1:0] wide;

    // Handshake flags depend on state only.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_q == ACT),
        .en_i  (accept),
        .a_i   (in_data),
        .b_i   (in_weight),
        .acc_o (acc)
    );

    // Bias add and rescale one bit wider than the accumulator so the sum
    // cannot overflow, then widen for the shared clamp function.
    always_comb begin
        sum_w   = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
        shifted = sum_w >>> SHIFT;
        wide    = {{(WIDE_W-ACC_W-1){shifted[ACC_W]}}, shifted};
    end

    // FSM next state, beat counter and output register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                        state_d = ACT;
                    end
                end
            end
            ACT: begin
                out_d   = relu_sat8(wide);
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            out_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: basic sums, ReLU/bias, saturation with
// and without shift, input gaps, output backpressure and mid-run reset.
module tb_neuron_mac;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic signed [7:0]  in_weight;
    logic signed [23:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out;
    logic               in_ready_s8;
    logic               out_valid_s8;
    logic [7:0]         out_s8;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_mac #(.N_INPUTS(4), .SHIFT(0), .ACC_W(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    neuron_mac #(.N_INPUTS(4), .SHIFT(8), .ACC_W(24)) dut_s8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s8),
        .in_data   (in_data),
        .in_weight (in_weight),
        .bias      (bias),
        .out_valid (out_valid_s8),
        .out_ready (out_ready),
        .out       (out_s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat presented for exactly one edge (accepted when in ACCUM).
    task automatic send_beat(input logic signed [7:0] d, input logic signed [7:0] w);
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        tick();
        in_valid  = 1'b0;
    endtask

    // Four back-to-back beats, then check latency, result and handshake.
    task automatic run_neuron(input string tag,
                              input logic signed [7:0] d0, input logic signed [7:0] d1,
                              input logic signed [7:0] d2, input logic signed [7:0] d3,
                              input logic signed [7:0] w,
                              input logic signed [23:0] b,
                              input logic [7:0] exp_out);
        bias = b;
        send_beat(d0, w);
        send_beat(d1, w);
        send_beat(d2, w);
        send_beat(d3, w);
        check({tag, "_act_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_act_ready"}, {31'd0, in_ready}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out"}, {24'd0, out}, {24'd0, exp_out});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_hold"}, {24'd0, out}, {24'd0, exp_out});
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        bias      = '0;
        out_ready = 1'b0;

        // Reset values.
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {24'd0, out}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic sum and ReLU/bias cases.
        run_neuron("basic", 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd1, 24'sd0, 8'd10);
        run_neuron("relu_neg", 8'sd10, 8'sd10, 8'sd10, 8'sd10, -8'sd1, 24'sd30, 8'd0);
        run_neuron("relu_bias", 8'sd10, 8'sd10, 8'sd10, 8'sd10, -8'sd1, 24'sd50, 8'd10);

        // Saturation: the SHIFT=8 instance sees the same stream.
        bias = 24'sd0;
        for (int i = 0; i < 4; i++) send_beat(8'sd127, 8'sd127);
        tick();
        check("sat_valid", {31'd0, out_valid}, 32'd1);
        check("sat_out", {24'd0, out}, 32'd255);
        check("shift8_valid", {31'd0, out_valid_s8}, 32'd1);
        check("shift8_out", {24'd0, out_s8}, 32'd252);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Gapped input: result must still be 10, no early completion.
        for (int i = 1; i <= 4; i++) begin
            send_beat(8'(i), 8'sd1);
            check("gap_ready", {31'd0, in_ready}, (i == 4) ? 32'd0 : 32'd1);
            check("gap_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("gap_valid", {31'd0, out_valid}, 32'd1);
        check("gap_out", {24'd0, out}, 32'd10);

        // Backpressure with an input waiting that must not be taken.
        in_valid  = 1'b1;
        in_data   = 8'sd100;
        in_weight = 8'sd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out", {24'd0, out}, 32'd10);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_released", {31'd0, out_valid}, 32'd0);
        check("bp_accum", {31'd0, in_ready}, 32'd1);
        run_neuron("after_bp", 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 24'sd0, 8'd4);

        // Reset mid-accumulation discards the partial sum.
        send_beat(8'sd50, 8'sd50);
        send_beat(8'sd50, 8'sd50);
        reset = 1'b0;
        #1;
        check("midrst_out", {24'd0, out}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        run_neuron("post_rst", 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd2, 24'sd0, 8'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
